mnist_frame_streamer: RTL

Synthesizable, parametrised image source and scoreboard for the `mnist_cnn` classifier. It reads image pixels from an external synchronous ROM and streams them to the classifier over a valid/ready handshake with full backpressure. After each image it waits for the classifier's `valid_out`, compares `decision` against a label ROM and counts correct classifications. Per-image reset pulses, timeout and protocol checks turn the one-shot simulation stimulus into an on-chip self-test engine for the classifier datapath.

---
 rtl/mnist_frame_streamer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mnist_frame_streamer.sv
// mnist_frame_streamer: streams ROM images to the mnist_cnn classifier and scores its decisions against a label ROM
module mnist_frame_streamer #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int NUM_IMG = 100,
  parameter int ADDR_W = 17,
  parameter int CLASS_W = 4,
  parameter int TIMEOUT = 4096,
  localparam int PIX = IMG_W * IMG_H,
  localparam int LA_W = NUM_IMG > 1 ? $clog2(NUM_IMG) : 1,
  localparam int CNT_W = $clog2(NUM_IMG + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic               lbl_en,
  output logic [LA_W-1:0]    lbl_addr,
  input  logic [CLASS_W-1:0] lbl_rdata,
  output logic [PIXEL_W-1:0] pixel,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               cnn_rst,
  input  logic [CLASS_W-1:0] decision,
  input  logic               valid_out,
  output logic               result_valid,
  output logic [CLASS_W-1:0] result_class,
  output logic [CLASS_W-1:0] result_label,
  output logic               result_match,
  output logic [CNT_W-1:0]   img_index,
  output logic [CNT_W-1:0]   correct_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic               proto_err
);
  localparam int PW = $clog2(PIX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT_RES, LABEL, NEXT, DONE} state_t;

  state_t state, state_n;
  logic [PW-1:0] fetch_cnt, sent_cnt;
  logic [TW-1:0] tcnt;
  logic [ADDR_W-1:0] base;
  logic [PIXEL_W-1:0] f0, f1, head;
  logic [1:0] fc;
  logic rd_v, pop, last, res_v, to_hit, tflag, match, hit, start_run;
  logic [CLASS_W-1:0] cls, lbl;

  // returning ROM word bypasses the FIFO when it is empty, so the first pixel is valid the cycle it returns
  assign head = fc != 2'd0 ? f0 : mem_rdata;
  assign pixel_valid = state == STREAM && (fc != 2'd0 || rd_v);
  assign pixel = pixel_valid ? head : '0;
  assign pop = pixel_valid && pixel_ready;
  assign last = pop && sent_cnt == PW'(PIX - 1);
  assign to_hit = state == WAIT_RES && !valid_out && tcnt == TW'(TIMEOUT - 1);
  assign mem_en = state == STREAM && fetch_cnt < PW'(PIX) && fc + {1'b0, rd_v} < 2'd2;
  assign mem_addr = base + ADDR_W'(fetch_cnt);
  assign lbl_en = state == WAIT_RES && (valid_out || to_hit);
  assign lbl_addr = LA_W'(img_index);
  assign cnn_rst = rst || state == CLR;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign hit = !tflag && cls == lbl_rdata;
  assign start_run = state == IDLE && start;
  assign result_valid = res_v;
  assign result_class = cls;
  assign result_label = lbl;
  assign result_match = match;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = start ? CLR : IDLE;
      CLR:      state_n = STREAM;
      STREAM:   state_n = last ? WAIT_RES : STREAM;
      WAIT_RES: state_n = lbl_en ? LABEL : WAIT_RES;
      LABEL:    state_n = NEXT;
      NEXT:     state_n = img_index == CNT_W'(NUM_IMG - 1) ? DONE : CLR;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_cnt <= '0;
      sent_cnt <= '0;
      tcnt <= '0;
      base <= '0;
      f0 <= '0;
      f1 <= '0;
      fc <= '0;
      rd_v <= 1'b0;
      res_v <= 1'b0;
      tflag <= 1'b0;
      cls <= '0;
      lbl <= '0;
      match <= 1'b0;
      img_index <= '0;
      correct_count <= '0;
      timeout_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      rd_v <= mem_en;
      res_v <= state == LABEL;
      fc <= state == CLR ? 2'd0 : fc + {1'b0, rd_v} - {1'b0, pop};
      f0 <= pop ? (fc == 2'd2 ? f1 : mem_rdata) : (fc == 2'd0 ? mem_rdata : f0);
      f1 <= !pop && fc == 2'd1 ? mem_rdata : f1;
      fetch_cnt <= state == CLR ? '0 : fetch_cnt + PW'(mem_en);
      sent_cnt <= state == CLR ? '0 : sent_cnt + PW'(pop);
      tcnt <= state == WAIT_RES ? tcnt + TW'(1) : '0;
      proto_err <= (proto_err && !start_run) || (valid_out && state != WAIT_RES);
      timeout_err <= (timeout_err && !start_run) || to_hit;
      if (start_run) begin
        img_index <= '0;
        correct_count <= '0;
        base <= '0;
      end
      if (lbl_en) begin
        cls <= valid_out ? decision : '0;
        tflag <= !valid_out;
      end
      if (state == LABEL) begin
        lbl <= lbl_rdata;
        match <= hit;
        correct_count <= correct_count + CNT_W'(hit);
      end
      if (state == NEXT) begin
        img_index <= img_index + CNT_W'(1);
        base <= base + ADDR_W'(PIX);
      end
    end
  end
endmodule
